mont_exp_multi_ctrl: RTL and testbench



---
 rtl/mont_exp_multi_ctrl_if.sv | 33 +++
 rtl/mont_exp_multi_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mont_exp_multi_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mont_exp_multi_ctrl_if.sv
// Host-side bus of the Montgomery exponentiation controller: the ARM command
// port (port1), the status port (port2) and the BRAM operand/result buses.
//
// Handshakes: port1_valid offers a command, and port1_read pulses for one
// cycle when it is taken. port2_valid and bram_dout_valid stay high until
// the matching read strobe is sampled and drop on the following cycle.
// bram_din is taken only on a cycle where bram_din_valid is high.
interface mont_exp_multi_ctrl_if #(
    parameter int NUM_CORES = 2,
    parameter int DATA_W    = 512
);
    logic [31:0]                  port1_din;
    logic                         port1_valid;
    logic                         port1_read;
    logic [31:0]                  port2_dout;
    logic                         port2_valid;
    logic                         port2_read;
    logic [NUM_CORES*DATA_W-1:0]  bram_din;
    logic                         bram_din_valid;
    logic [NUM_CORES*DATA_W-1:0]  bram_dout;
    logic                         bram_dout_valid;
    logic                         bram_dout_read;

    modport master (
        output port1_din, port1_valid, port2_read, bram_din, bram_din_valid, bram_dout_read,
        input  port1_read, port2_dout, port2_valid, bram_dout, bram_dout_valid
    );

    modport slave (
        input  port1_din, port1_valid, port2_read, bram_din, bram_din_valid, bram_dout_read,
        output port1_read, port2_dout, port2_valid, bram_dout, bram_dout_valid
    );
endinterface

// File: rtl/mont_exp_multi_ctrl.sv
// Command/data controller for a bank of NUM_CORES Montgomery exponentiation
// cores. It decodes port1 commands, loads the operand banks, starts a masked
// set of cores, tracks sticky done flags and reports status on port2.
// Optional build macro MONT_CTRL_TIMEOUT_EN adds a WAIT watchdog (code 2).
module mont_exp_multi_ctrl #(
    parameter int NUM_CORES      = 2,
    parameter int DATA_W         = 512,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                         clk,
    input  logic                         resetn,
    mont_exp_multi_ctrl_if.slave         host,
    output logic [NUM_CORES*DATA_W-1:0]  core_x,
    output logic [NUM_CORES*DATA_W-1:0]  core_e,
    output logic [NUM_CORES*DATA_W-1:0]  core_m,
    output logic [NUM_CORES*DATA_W-1:0]  core_rm,
    output logic [NUM_CORES*DATA_W-1:0]  core_r2m,
    output logic [NUM_CORES-1:0]         core_start,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES*DATA_W-1:0]  core_result,
    output logic [3:0]                   leds
);
    localparam int BW = NUM_CORES * DATA_W;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_LOAD  = 4'd1;
    localparam logic [3:0] ST_START = 4'd2;
    localparam logic [3:0] ST_WAIT  = 4'd3;
    localparam logic [3:0] ST_WRITE = 4'd4;
    localparam logic [3:0] ST_RESP  = 4'd5;

    // Only the opcode and the mask bits of real cores carry meaning.
    localparam logic [31:0] CMD_USED = {16'(((32'd1 << NUM_CORES) - 32'd1)), 12'h000, 4'hF};

    logic [3:0]           state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [3:0]           code_q, code_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [NUM_CORES-1:0] done_q, done_d;
    logic                 port1_read_q, port1_read_d;
    logic                 bram_dout_valid_q, bram_dout_valid_d;
    logic [BW-1:0]        bram_dout_q, bram_dout_d;
    logic [BW-1:0]        x_q, x_d, e_q, e_d, m_q, m_d, rm_q, rm_d, r2m_q, r2m_d;
    logic [15:0]          done_ext;
    logic                 unused_cmd_bits;

`ifdef MONT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    assign unused_cmd_bits = ^(host.port1_din & ~CMD_USED);

    // Next-state decode for the command FSM and all datapath registers.
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        code_d            = code_q;
        mask_d            = mask_q;
        done_d            = done_q;
        port1_read_d      = 1'b0;
        bram_dout_valid_d = bram_dout_valid_q;
        bram_dout_d       = bram_dout_q;
        x_d               = x_q;
        e_d               = e_q;
        m_d               = m_q;
        rm_d              = rm_q;
        r2m_d             = r2m_q;
`ifdef MONT_CTRL_TIMEOUT_EN
        tmo_d             = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (host.port1_valid) begin
                    port1_read_d = 1'b1;
                    op_d         = host.port1_din[3:0];
                    mask_d       = host.port1_din[16 +: NUM_CORES];
                    code_d       = 4'd0;
                    case (host.port1_din[3:0])
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: state_d = ST_LOAD;
                        4'd5: state_d = ST_START;
                        4'd6: begin
                            state_d           = ST_WRITE;
                            bram_dout_d       = core_result;
                            bram_dout_valid_d = 1'b1;
                        end
                        4'd7: state_d = ST_RESP;
                        default: begin
                            state_d = ST_RESP;
                            code_d  = 4'd1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (host.bram_din_valid) begin
                    case (op_q)
                        4'd0:    x_d   = host.bram_din;
                        4'd1:    e_d   = host.bram_din;
                        4'd2:    m_d   = host.bram_din;
                        4'd3:    r2m_d = host.bram_din;
                        default: rm_d  = host.bram_din;
                    endcase
                    state_d = ST_RESP;
                    code_d  = 4'd0;
                end
            end
            ST_START: begin
                if (mask_q == '0) begin
                    state_d = ST_RESP;
                    code_d  = 4'd3;
                end else begin
                    // Any done seen in this cycle is dropped on purpose.
                    done_d  = done_q & ~mask_q;
                    state_d = ST_WAIT;
`ifdef MONT_CTRL_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                done_d = done_q | (core_done & mask_q);
                if ((done_d & mask_q) == mask_q) begin
                    state_d = ST_RESP;
                    code_d  = 4'd0;
                end
`ifdef MONT_CTRL_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RESP;
                    code_d  = 4'd2;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_WRITE: begin
                if (host.bram_dout_read) begin
                    bram_dout_valid_d = 1'b0;
                    state_d           = ST_RESP;
                    code_d            = 4'd0;
                end
            end
            ST_RESP: begin
                if (host.port2_read) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q           <= ST_IDLE;
            op_q              <= '0;
            code_q            <= '0;
            mask_q            <= '0;
            done_q            <= '0;
            port1_read_q      <= 1'b0;
            bram_dout_valid_q <= 1'b0;
            bram_dout_q       <= '0;
            x_q               <= '0;
            e_q               <= '0;
            m_q               <= '0;
            rm_q              <= '0;
            r2m_q             <= '0;
`ifdef MONT_CTRL_TIMEOUT_EN
            tmo_q             <= '0;
`endif
        end else begin
            state_q           <= state_d;
            op_q              <= op_d;
            code_q            <= code_d;
            mask_q            <= mask_d;
            done_q            <= done_d;
            port1_read_q      <= port1_read_d;
            bram_dout_valid_q <= bram_dout_valid_d;
            bram_dout_q       <= bram_dout_d;
            x_q               <= x_d;
            e_q               <= e_d;
            m_q               <= m_d;
            rm_q              <= rm_d;
            r2m_q             <= r2m_d;
`ifdef MONT_CTRL_TIMEOUT_EN
            tmo_q             <= tmo_d;
`endif
        end
    end

    // Zero-extend the sticky done flags into the 16-bit status field.
    always_comb begin
        done_ext                = '0;
        done_ext[NUM_CORES-1:0] = done_q;
    end

    assign host.port1_read      = port1_read_q;
    assign host.port2_valid     = (state_q == ST_RESP);
    assign host.port2_dout      = {done_ext, 12'h000, code_q};
    assign host.bram_dout       = bram_dout_q;
    assign host.bram_dout_valid = bram_dout_valid_q;
    assign core_x               = x_q;
    assign core_e               = e_q;
    assign core_m               = m_q;
    assign core_rm              = rm_q;
    assign core_r2m             = r2m_q;
    assign core_start           = (state_q == ST_START) ? mask_q : '0;
    assign leds                 = state_q;
endmodule

// File: tb/tb_mont_exp_multi_ctrl.sv
// Directed bench for mont_exp_multi_ctrl (2 cores, 32-bit operands).
module tb_mont_exp_multi_ctrl;
    localparam int NC = 2;
    localparam int DW = 32;
    localparam int BW = NC * DW;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_START = 4'd2;
    localparam logic [3:0] S_WRITE = 4'd4;
    localparam logic [3:0] S_RESP  = 4'd5;

    logic          clk = 1'b0;
    logic          resetn;
    logic [BW-1:0] core_x, core_e, core_m, core_rm, core_r2m;
    logic [NC-1:0] core_start;
    logic [NC-1:0] core_done;
    logic [BW-1:0] core_result;
    logic [3:0]    leds;

    int n_vec = 0;
    int n_bad = 0;

    mont_exp_multi_ctrl_if #(.NUM_CORES(NC), .DATA_W(DW)) host_if ();

    mont_exp_multi_ctrl #(.NUM_CORES(NC), .DATA_W(DW), .TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .host        (host_if),
        .core_x      (core_x),
        .core_e      (core_e),
        .core_m      (core_m),
        .core_rm     (core_rm),
        .core_r2m    (core_r2m),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .leds        (leds)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [15:0] mask);
        host_if.port1_din   = {mask, 12'h000, op};
        host_if.port1_valid = 1'b1;
        tick();
        host_if.port1_valid = 1'b0;
        chk("port1_read_pulse", 64'(host_if.port1_read), 64'd1);
    endtask

    task automatic rd_resp(input string tag, input logic [31:0] exp);
        chk({tag, "_p2valid"}, 64'(host_if.port2_valid), 64'd1);
        chk({tag, "_p2dout"}, 64'(host_if.port2_dout), 64'(exp));
        host_if.port2_read = 1'b1;
        tick();
        host_if.port2_read = 1'b0;
        chk({tag, "_p2drop"}, 64'(host_if.port2_valid), 64'd0);
        chk({tag, "_idle"}, 64'(leds), 64'(S_IDLE));
    endtask

    task automatic load_bank(input logic [3:0] op, input logic [BW-1:0] data);
        host_if.bram_din = data;
        send_cmd(op, 16'h0000);
        chk("load_state", 64'(leds), 64'(S_LOAD));
        // a command offered outside IDLE must be ignored
        host_if.port1_din   = 32'h0000_0007;
        host_if.port1_valid = 1'b1;
        tick();
        host_if.port1_valid = 1'b0;
        chk("load_no_p1read", 64'(host_if.port1_read), 64'd0);
        chk("load_still_load", 64'(leds), 64'(S_LOAD));
        host_if.bram_din_valid = 1'b1;
        tick();
        host_if.bram_din_valid = 1'b0;
        host_if.bram_din       = '0;
    endtask

    initial begin : stim
        int first;
        resetn                 = 1'b0;
        core_done              = '0;
        core_result            = '0;
        host_if.port1_din      = '0;
        host_if.port1_valid    = 1'b0;
        host_if.port2_read     = 1'b0;
        host_if.bram_din       = '0;
        host_if.bram_din_valid = 1'b0;
        host_if.bram_dout_read = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_leds", 64'(leds), 64'(S_IDLE));
        chk("rst_p1read", 64'(host_if.port1_read), 64'd0);
        chk("rst_p2valid", 64'(host_if.port2_valid), 64'd0);
        chk("rst_bvalid", 64'(host_if.bram_dout_valid), 64'd0);
        chk("rst_start", 64'(core_start), 64'd0);
        chk("rst_core_x", 64'(core_x), 64'd0);
        chk("rst_p2dout", 64'(host_if.port2_dout), 64'd0);
        resetn = 1'b1;
        tick();

        // LOAD X, then LOAD E: the other bank must stay untouched
        load_bank(4'd0, 64'h2222_2222_1111_1111);
        chk("x_bank", 64'(core_x), 64'h2222_2222_1111_1111);
        chk("x_e_untouched", 64'(core_e), 64'd0);
        rd_resp("load_x", 32'h0000_0000);
        load_bank(4'd1, 64'hAAAA_5555_0F0F_F0F0);
        chk("e_bank", 64'(core_e), 64'hAAAA_5555_0F0F_F0F0);
        chk("e_x_kept", 64'(core_x), 64'h2222_2222_1111_1111);
        rd_resp("load_e", 32'h0000_0000);
        load_bank(4'd3, 64'h0123_4567_89AB_CDEF);
        chk("r2m_bank", 64'(core_r2m), 64'h0123_4567_89AB_CDEF);
        chk("r2m_rm_untouched", 64'(core_rm), 64'd0);
        rd_resp("load_r2m", 32'h0000_0000);

        // EXP on core 0 only; done in START ignored, core 1 done ignored
        send_cmd(4'd5, 16'h0001);
        chk("exp1_start", 64'(core_start), 64'b01);
        core_done = 2'b01;
        tick();
        chk("exp1_start_drop", 64'(core_start), 64'd0);
        first = 0;
        for (int c = 1; c <= 12; c++) begin
            core_done = {c[0], (c == 9)};
            tick();
            if (host_if.port2_valid && first == 0) first = c;
        end
        core_done = '0;
        chk("exp1_finish_cycle", 64'(first), 64'd9);
        rd_resp("exp1", 32'h0001_0000);

        // EXP on both cores, done at +10 and +40
        send_cmd(4'd5, 16'h0003);
        chk("exp3_start", 64'(core_start), 64'b11);
        chk("exp3_state", 64'(leds), 64'(S_START));
        tick();
        first = 0;
        for (int c = 1; c <= 45; c++) begin
            core_done = {(c == 40), (c == 10)};
            tick();
            if (host_if.port2_valid && first == 0) first = c;
        end
        core_done = '0;
        chk("exp3_finish_cycle", 64'(first), 64'd40);
        rd_resp("exp3", 32'h0003_0000);

        // empty mask and mask bits above NUM_CORES: code 3, no start
        send_cmd(4'd5, 16'h0000);
        chk("mask0_nostart", 64'(core_start), 64'd0);
        tick();
        rd_resp("mask0", 32'h0003_0003);
        send_cmd(4'd5, 16'hFFFC);
        chk("maskhi_nostart", 64'(core_start), 64'd0);
        tick();
        rd_resp("maskhi", 32'h0003_0003);

        // illegal opcode and STATUS
        send_cmd(4'hA, 16'h0000);
        rd_resp("illegal", 32'h0003_0001);
        send_cmd(4'd7, 16'h0000);
        rd_resp("status", 32'h0003_0000);

        // WRITE with read delayed; result captured on entry
        core_result = 64'hCAFE_0001_BEEF_0002;
        send_cmd(4'd6, 16'h0000);
        chk("wr_state", 64'(leds), 64'(S_WRITE));
        chk("wr_valid", 64'(host_if.bram_dout_valid), 64'd1);
        chk("wr_data", 64'(host_if.bram_dout), 64'hCAFE_0001_BEEF_0002);
        core_result = 64'h1234_5678_9ABC_DEF0;
        first = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (host_if.bram_dout_valid) first++;
        end
        chk("wr_held", 64'(first), 64'd4);
        host_if.bram_dout_read = 1'b1;
        tick();
        host_if.bram_dout_read = 1'b0;
        chk("wr_drop", 64'(host_if.bram_dout_valid), 64'd0);
        chk("wr_data_kept", 64'(host_if.bram_dout), 64'hCAFE_0001_BEEF_0002);
        rd_resp("write", 32'h0003_0000);

`ifdef MONT_CTRL_TIMEOUT_EN
        // watchdog: core 0 never finishes
        send_cmd(4'd5, 16'h0001);
        tick();
        first = 0;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (host_if.port2_valid && first == 0) first = c;
        end
        chk("tmo_cycle", 64'(first), 64'd100);
        rd_resp("tmo", 32'h0002_0002);
`endif

        // reset pulse in WAIT
        send_cmd(4'd5, 16'h0003);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_leds", 64'(leds), 64'(S_IDLE));
        chk("mid_rst_start", 64'(core_start), 64'd0);
        chk("mid_rst_p2valid", 64'(host_if.port2_valid), 64'd0);
        chk("mid_rst_core_x", 64'(core_x), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        send_cmd(4'd7, 16'h0000);
        chk("post_rst_state", 64'(leds), 64'(S_RESP));
        rd_resp("post_rst", 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
